// File: rtl/acc_mb_ctrl.sv
// Avalon-MM slave front-end for a multi-block SHA-256 core.
// Buffers one 512-bit block, sequences the core and exposes the digest.
module acc_mb_ctrl #(
    parameter int DW     = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DW-1:0]     writedata,
    output logic [DW-1:0]     readdata,
    output logic              irq,
    output logic              core_start,
    output logic              core_init,
    output logic [511:0]      core_block,
    input  logic              core_done,
    input  logic [255:0]      core_digest
);

    localparam int NW  = 512 / DW;
    localparam int NDG = 256 / DW;

    localparam logic [31:0] A_CTRL = 32'(NW);
    localparam logic [31:0] A_STAT = 32'(NW + 1);
    localparam logic [31:0] A_DIG  = 32'(NW + 2);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic [511:0]  blk;
    logic [255:0]  digest;
    logic [NW-1:0] mask;
    logic          ien;
    logic          done;
    logic          err;

    logic [31:0]   addr;
    logic          wr;
    logic          rd;
    logic          wr_blk;
    logic          wr_ctrl;
    logic          rd_stat;
    logic          go;
    logic          go_ok;
    logic          go_bad;
    logic          blk_bad;
    logic          run_done;
    logic [DW-1:0] rdata_nxt;

    assign addr    = 32'(address);
    assign wr      = chipselect & write;
    assign rd      = chipselect & read;
    assign wr_blk  = wr && (addr < A_CTRL);
    assign wr_ctrl = wr && (addr == A_CTRL);
    assign rd_stat = rd && (addr == A_STAT);
    assign go      = wr_ctrl & writedata[0];

    assign core_block = blk;
    assign irq        = done & ien;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        go_ok     = 1'b0;
        go_bad    = 1'b0;
        blk_bad   = 1'b0;
        run_done  = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    if (&mask) begin
                        go_ok     = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        go_bad = 1'b1;
                    end
                end
            end
            RUN: begin
                if (core_done) begin
                    run_done  = 1'b1;
                    state_nxt = IDLE;
                end
                // the core reads core_block throughout RUN, so host writes bounce
                if (go || wr_blk) begin
                    blk_bad = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdata_nxt = '0;
        if (addr == A_STAT) begin
            rdata_nxt = DW'({mask, err, done, state == RUN});
        end
        for (int j = 0; j < NDG; j++) begin
            if (addr == A_DIG + 32'(j)) begin
                rdata_nxt = digest[DW*j +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk        <= '0;
            digest     <= '0;
            mask       <= '0;
            ien        <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            core_start <= 1'b0;
            core_init  <= 1'b0;
            readdata   <= '0;
        end else begin
            core_start <= go_ok;
            readdata   <= rd ? rdata_nxt : '0;

            if (go_ok) begin
                core_init <= writedata[1];
                mask      <= '0;
            end

            if (wr_ctrl) begin
                ien <= writedata[2];
            end

            if (wr_blk && state == IDLE) begin
                for (int i = 0; i < NW; i++) begin
                    if (addr == 32'(i)) begin
                        blk[DW*i +: DW] <= writedata;
                        mask[i]         <= 1'b1;
                    end
                end
            end

            if (run_done) begin
                digest <= core_digest;
            end

            // set events win over the read-to-clear of the same cycle
            if (rd_stat || go_ok) begin
                done <= 1'b0;
            end
            if (run_done) begin
                done <= 1'b1;
            end

            if (rd_stat) begin
                err <= 1'b0;
            end
            if (go_bad || blk_bad) begin
                err <= 1'b1;
            end
        end
    end

endmodule
